// File: rtl/sar_conv_responder.sv
// rtl/sar_conv_responder.sv - soc/eoc responder running an 8-bit successive-approximation search
// Optional build macro: CMP_SYNC_EN (2-flop comparator synchronizer, two extra settle edges per bit)

module sar_conv_responder #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             soc,
    output logic             eoc,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] dac,
    input  logic             cmp
);

    logic cmp_s;

`ifdef CMP_SYNC_EN
    // Trial code is held two extra edges so the synchronizer output reflects the current dac
    localparam int HOLD = SETTLE_CYCLES + 2;

    logic [1:0] cmp_sync;

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            cmp_sync <= 2'b00;
        end else begin
            cmp_sync <= {cmp_sync[0], cmp};
        end
    end

    assign cmp_s = cmp_sync[1];
`else
    localparam int HOLD = SETTLE_CYCLES;

    assign cmp_s = cmp;
`endif

    localparam int CW = $clog2(HOLD + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_TRIAL,
        S_DECIDE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    bit_idx, bit_n;
    logic             eoc_n;
    logic [WIDTH-1:0] x_n, dac_n;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] kept;

    // One-hot mask of the bit under trial; the comparator decides whether it survives
    assign mask = WIDTH'(1) << bit_idx;
    assign kept = cmp_s ? dac : (dac & ~mask);

    // State and datapath registers; every output comes straight from a flop
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            eoc     <= 1'b1;
            x       <= '0;
            dac     <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            eoc     <= eoc_n;
            x       <= x_n;
            dac     <= dac_n;
        end
    end

    // Handshake sequencing and the per-bit settle/decide search
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        eoc_n   = eoc;
        x_n     = x;
        dac_n   = dac;
        case (state)
            S_IDLE: begin
                if (soc) begin
                    state_n = S_ACK;
                    eoc_n   = 1'b0;
                end
            end
            S_ACK: begin
                // Wait for the consumer to release soc before starting
                if (!soc) begin
                    state_n = S_TRIAL;
                    dac_n   = WIDTH'(1) << (WIDTH - 1);
                    bit_n   = IW'(WIDTH - 1);
                    cnt_n   = '0;
                end
            end
            S_TRIAL: begin
                if (cnt == CW'(HOLD - 1)) begin
                    state_n = S_DECIDE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DECIDE: begin
                if (bit_idx == '0) begin
                    state_n = S_IDLE;
                    x_n     = kept;
                    eoc_n   = 1'b1;
                    dac_n   = '0;
                end else begin
                    state_n = S_TRIAL;
                    dac_n   = kept | (mask >> 1);
                    bit_n   = bit_idx - 1'b1;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_conv_responder.sv
// tb/tb_sar_conv_responder.sv - randomized self-checking bench for sar_conv_responder

module tb_sar_conv_responder;

    localparam int W = 8;
    localparam int S = 2;
`ifdef CMP_SYNC_EN
    localparam int P = S + 3;
`else
    localparam int P = S + 1;
`endif
    localparam int LAT = W * P;

    logic         clock;
    logic         reset_;
    logic         soc;
    logic         eoc;
    logic [W-1:0] x;
    logic [W-1:0] dac;
    logic         cmp;
    logic [W-1:0] v_in;

    int checks = 0;
    int errors = 0;

    sar_conv_responder #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .eoc    (eoc),
        .x      (x),
        .dac    (dac),
        .cmp    (cmp)
    );

    // Ideal comparator against the analog level v_in
    assign cmp = (v_in >= dac);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected trial code n edges into a conversion: bits above the trial bit come from the
    // answer, the trial bit itself is set, everything below is clear
    function automatic logic [W-1:0] trial_code(input logic [W-1:0] v, input int n);
        int b;
        int hi;
        b  = (W - 1) - n / P;
        hi = int'(v) & ~((1 << (b + 1)) - 1);
        return W'(hi | (1 << b));
    endfunction

    // Behavioural model: phase 0 idle, 1 waiting for soc release, 2 converting
    int           m_phase = 0;
    int           m_n     = 0;
    logic [W-1:0] m_v     = '0;
    logic [W-1:0] m_x     = '0;
    logic [W-1:0] m_dac   = '0;
    logic         m_eoc   = 1'b1;

    always @(posedge clock or posedge reset_) begin
        if (reset_) begin
            m_phase = 0;
            m_n     = 0;
            m_x     = '0;
            m_dac   = '0;
            m_eoc   = 1'b1;
        end else begin
            case (m_phase)
                0: if (soc) begin
                    m_phase = 1;
                    m_eoc   = 1'b0;
                end
                1: if (!soc) begin
                    m_phase = 2;
                    m_n     = 0;
                    m_v     = v_in;
                    m_dac   = trial_code(v_in, 0);
                end
                default: begin
                    m_n = m_n + 1;
                    if (m_n == LAT) begin
                        m_phase = 0;
                        m_eoc   = 1'b1;
                        m_x     = m_v;
                        m_dac   = '0;
                    end else begin
                        m_dac = trial_code(m_v, m_n);
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clock) begin
        check("eoc", 32'(eoc), 32'(m_eoc));
        check("x",   32'(x),   32'(m_x));
        check("dac", 32'(dac), 32'(m_dac));
    end

    // Raise soc for hold sampled edges, then release it
    task automatic start_req(input logic [W-1:0] v, input int hold);
        @(negedge clock);
        v_in = v;
        soc  = 1'b1;
        repeat (hold) @(negedge clock);
        soc = 1'b0;
    endtask

    // Follow a conversion whose soc has just been released.
    // mode 0: soc quiet; 1: random soc toggling, released at the end; 2: soc raised again mid-way
    task automatic finish_conv(input logic [W-1:0] expv, input int mode, input bit pin_seq);
        int edges;
        @(negedge clock);
        edges = 0;
        if (pin_seq) check("dac_seq0", 32'(dac), 32'h80);
        while (1) begin
            @(negedge clock);
            edges++;
            if (eoc || edges >= 200) break;
            if (pin_seq && edges == P)     check("dac_seq1", 32'(dac), 32'hC0);
            if (pin_seq && edges == 2 * P) check("dac_seq2", 32'(dac), 32'hA0);
            if (pin_seq && edges == 3 * P) check("dac_seq3", 32'(dac), 32'hB0);
            if (mode == 1) soc = 1'($urandom_range(0, 1));
            if (mode == 2 && edges == 5) soc = 1'b1;
        end
        check("latency", 32'(edges), 32'(LAT));
        check("result", 32'(x), 32'(expv));
        if (mode == 1) soc = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rv;
        reset_ = 1'b1;
        soc    = 1'b0;
        v_in   = '0;
        #1;
        check("rst_eoc", 32'(eoc), 32'h1);
        check("rst_x",   32'(x),   32'h0);
        check("rst_dac", 32'(dac), 32'h0);
        repeat (2) @(negedge clock);
        reset_ = 1'b0;
        repeat (2) @(negedge clock);

        // Single conversion with the trial sequence pinned
        start_req(8'hA5, 1);
        finish_conv(8'hA5, 0, 1'b1);
        check("x_A5", 32'(x), 32'hA5);

        // Back-to-back: all zeros then all ones, soc re-raised mid conversion
        start_req(8'h00, 1);
        finish_conv(8'h00, 2, 1'b0);
        v_in = 8'hFF;
        @(negedge clock);
        check("b2b_eoc_low", 32'(eoc), 32'h0);
        soc = 1'b0;
        finish_conv(8'hFF, 0, 1'b0);

        // soc held for 10 cycles: nothing starts while it is high
        start_req(8'h6E, 10);
        check("hold_eoc", 32'(eoc), 32'h0);
        check("hold_dac", 32'(dac), 32'h0);
        finish_conv(8'h6E, 0, 1'b0);

        // soc toggled during the search, then result must stay put
        start_req(8'h37, 1);
        finish_conv(8'h37, 1, 1'b0);
        repeat (5) @(negedge clock);
        check("x_stable", 32'(x), 32'h37);

        // Asynchronous reset in the middle of a conversion
        start_req(8'h5A, 1);
        repeat (10) @(posedge clock);
        #2;
        reset_ = 1'b1;
        #1;
        check("abort_eoc", 32'(eoc), 32'h1);
        check("abort_x",   32'(x),   32'h0);
        check("abort_dac", 32'(dac), 32'h0);
        @(negedge clock);
        reset_ = 1'b0;
        @(negedge clock);
        check("post_rst_eoc", 32'(eoc), 32'h1);

        // Sync-path reference value
        start_req(8'h3C, 1);
        finish_conv(8'h3C, 0, 1'b0);

        // Randomized conversions
        for (int i = 0; i < 16; i++) begin
            rv = W'($urandom);
            start_req(rv, $urandom_range(1, 3));
            finish_conv(rv, $urandom_range(0, 1), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
